hex_bank_display: RTL and testbench

HEX_BANK_DISPLAY -- requirements
Module: hex_bank_display

---
 rtl/hex_bank_display_pkg.sv | 28 ++
 rtl/hex_seg_decode.sv | 32 +++
 rtl/hex_bank_display.sv | 89 ++++++++
 tb/tb_hex_bank_display.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_bank_display_pkg.sv
// Shared seven-segment definitions for display blocks.
// Segment vectors are active-low; bit 0 is segment a, bit 6 is segment g.
package hex_bank_display_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned NIB_W = 4;

   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t SEG_0   = 7'b1000000;
   localparam seg_t SEG_1   = 7'b1111001;
   localparam seg_t SEG_2   = 7'b0100100;
   localparam seg_t SEG_3   = 7'b0110000;
   localparam seg_t SEG_4   = 7'b0011001;
   localparam seg_t SEG_5   = 7'b0010010;
   localparam seg_t SEG_6   = 7'b0000010;
   localparam seg_t SEG_7   = 7'b1111000;
   localparam seg_t SEG_8   = 7'b0000000;
   localparam seg_t SEG_9   = 7'b0010000;
   localparam seg_t SEG_A   = 7'b0001000;
   localparam seg_t SEG_B   = 7'b0000011;
   localparam seg_t SEG_C   = 7'b1000110;
   localparam seg_t SEG_D   = 7'b0100001;
   localparam seg_t SEG_E   = 7'b0000110;
   localparam seg_t SEG_F   = 7'b0001110;
   localparam seg_t SEG_OFF = 7'b1111111;

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-low seven-segment decode.
module hex_seg_decode
   import hex_bank_display_pkg::*;
(
   input  logic [NIB_W-1:0] nibble,
   output seg_t             seg_c
);

   always_comb begin
      seg_c = SEG_OFF;
      case (nibble)
         4'h0: seg_c = SEG_0;
         4'h1: seg_c = SEG_1;
         4'h2: seg_c = SEG_2;
         4'h3: seg_c = SEG_3;
         4'h4: seg_c = SEG_4;
         4'h5: seg_c = SEG_5;
         4'h6: seg_c = SEG_6;
         4'h7: seg_c = SEG_7;
         4'h8: seg_c = SEG_8;
         4'h9: seg_c = SEG_9;
         4'hA: seg_c = SEG_A;
         4'hB: seg_c = SEG_B;
         4'hC: seg_c = SEG_C;
         4'hD: seg_c = SEG_D;
         4'hE: seg_c = SEG_E;
         4'hF: seg_c = SEG_F;
         default: seg_c = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/hex_bank_display.sv
// Bank of seven-segment digits with a held value, leading-zero suppression,
// per-digit enables and whole-bank blink.
module hex_bank_display
   import hex_bank_display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned BLINK_DIV  = 25_000_000
)(
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NIB_W*NUM_DIGITS-1:0]         data,
   input  logic                                load,
   input  logic                                blank_lz,
   input  logic                                blink_en,
   input  logic [NUM_DIGITS-1:0]               digit_en,
   output logic [NUM_DIGITS-1:0][SEG_W-1:0]    HEX,
   output logic [NIB_W*NUM_DIGITS-1:0]         shown
);

   localparam int unsigned CNT_W = $clog2(BLINK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

   logic [CNT_W-1:0]                 blink_cnt;
   logic                             phase_on;
   seg_t                             dec_c [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]            lz_off_c;
   logic                             blank_all_c;
   logic [NUM_DIGITS-1:0][SEG_W-1:0] hex_next_c;

   // Value register; shown is the register itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shown <= '0;
      end else if (load) begin
         shown <= data;
      end
   end

   // Blink half-period counter; dropping blink_en restarts in the ON phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
         phase_on  <= 1'b1;
      end else if (!blink_en) begin
         blink_cnt <= '0;
         phase_on  <= 1'b1;
      end else if (blink_cnt == CNT_LAST) begin
         blink_cnt <= '0;
         phase_on  <= ~phase_on;
      end else begin
         blink_cnt <= blink_cnt + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      hex_seg_decode u_dec (
         .nibble (shown[NIB_W*g +: NIB_W]),
         .seg_c  (dec_c[g])
      );
   end

   // Suppression follows nibble values only, so enables never shift it.
   always_comb begin : lz_mask
      logic seen;
      seen     = 1'b0;
      lz_off_c = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         seen        = seen | (shown[NIB_W*i +: NIB_W] != '0);
         lz_off_c[i] = blank_lz & ~seen & (i != 0);
      end
   end

   always_comb begin
      blank_all_c = blink_en & ~phase_on;
      hex_next_c  = {NUM_DIGITS{SEG_OFF}};
      for (int i = 0; i < NUM_DIGITS; i++) begin
         hex_next_c[i] = (blank_all_c | ~digit_en[i] | lz_off_c[i]) ? SEG_OFF : dec_c[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         HEX <= {NUM_DIGITS{SEG_OFF}};
      end else begin
         HEX <= hex_next_c;
      end
   end

endmodule

// File: tb/tb_hex_bank_display.sv
// Scoreboard bench for hex_bank_display (NUM_DIGITS=6, BLINK_DIV=4).
module tb_hex_bank_display;

   localparam int unsigned ND = 6;
   localparam int unsigned BD = 4;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
   localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
   localparam logic [6:0] SO = 7'b1111111;
   localparam logic [41:0] OFF6 = {6{SO}};
   localparam logic [41:0] V012345 = {S0, S1, S2, S3, S4, S5};
   localparam logic [41:0] V00ABCD = {S0, S0, SA, SB, SC, SD};

   typedef struct packed {
      int          cyc;
      logic [41:0] hex;
      logic [23:0] shown;
      int          id;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [23:0]          data;
   logic                 load;
   logic                 blank_lz;
   logic                 blink_en;
   logic [ND-1:0]        digit_en;
   logic [ND-1:0][6:0]   HEX;
   logic [23:0]          shown;

   exp_t q[$];
   exp_t aq[$];
   event async_ev;
   int   ncyc  = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   hex_bank_display #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
      .clk      (clk),
      .reset    (reset),
      .data     (data),
      .load     (load),
      .blank_lz (blank_lz),
      .blink_en (blink_en),
      .digit_en (digit_en),
      .HEX      (HEX),
      .shown    (shown)
   );

   task automatic push(input int c, input logic [41:0] h, input logic [23:0] s, input int id);
      exp_t e;
      e.cyc = c; e.hex = h; e.shown = s; e.id = id;
      q.push_back(e);
   endtask

   task automatic push_async(input logic [41:0] h, input logic [23:0] s, input int id);
      exp_t e;
      e.cyc = -1; e.hex = h; e.shown = s; e.id = id;
      aq.push_back(e);
      -> async_ev;
   endtask

   task automatic compare(input exp_t e);
      tests++;
      if (HEX !== e.hex || shown !== e.shown) begin
         fails++;
         $display("FAIL chk%0d cyc=%0d HEX=%h expected %h shown=%h expected %h",
                  e.id, ncyc, HEX, e.hex, shown, e.shown);
      end
   endtask

   task automatic go();
      @(negedge clk);
   endtask

   // Edge-aligned monitor: checks every entry due at this edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         ncyc++;
         while (q.size() > 0 && q[0].cyc <= ncyc) begin
            e = q.pop_front();
            if (e.cyc < ncyc) begin
               tests++;
               fails++;
               $display("FAIL chk%0d missed at cyc %0d (due %0d)", e.id, ncyc, e.cyc);
            end else begin
               compare(e);
            end
         end
      end
   end

   // Between-edge monitor for asynchronous reset behaviour.
   initial begin
      forever begin
         @(async_ev);
         while (aq.size() > 0) compare(aq.pop_front());
      end
   end

   initial begin
      #20000;
      $display("FAIL timeout cyc=%0d", ncyc);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      bit on;
      reset = 1'b1; load = 1'b0; data = '0; blank_lz = 1'b0; blink_en = 1'b0;
      digit_en = 6'h3F;

      repeat (3) go();
      push_async(OFF6, 24'h0, 1);
      reset = 1'b0;
      push(ncyc + 1, {6{S0}}, 24'h0, 2);

      go(); blank_lz = 1'b1;
      push(ncyc + 1, {SO, SO, SO, SO, SO, S0}, 24'h0, 3);

      go(); load = 1'b1; data = 24'h0000A5; n = ncyc;
      push(n + 1, {SO, SO, SO, SO, SO, S0}, 24'h0000A5, 4);
      push(n + 2, {SO, SO, SO, SO, SA, S5}, 24'h0000A5, 5);
      go(); load = 1'b0;
      go(); blank_lz = 1'b0;
      push(ncyc + 1, {S0, S0, S0, S0, SA, S5}, 24'h0000A5, 6);

      go(); blank_lz = 1'b1; load = 1'b1; data = 24'h100203; n = ncyc;
      push(n + 2, {S1, S0, S0, S2, S0, S3}, 24'h100203, 7);
      go(); load = 1'b0;
      go();

      digit_en = 6'b111110; load = 1'b1; data = 24'h000007; n = ncyc;
      push(n + 1, {S1, S0, S0, S2, S0, SO}, 24'h000007, 8);
      push(n + 2, OFF6, 24'h000007, 9);
      go(); load = 1'b0;
      go();

      digit_en = 6'b111011; load = 1'b1; data = 24'h000700; n = ncyc;
      push(n + 2, {SO, SO, SO, SO, S0, S0}, 24'h000700, 10);
      go(); load = 1'b0;
      go();

      digit_en = 6'h3F; blank_lz = 1'b0; load = 1'b1; data = 24'hFEDCBA; n = ncyc;
      push(n + 2, {SF, SE, SD, SC, SB, SA}, 24'h987654, 11);
      push(n + 3, {S9, S8, S7, S6, S5, S4}, 24'h012345, 12);
      push(n + 4, V012345, 24'h012345, 13);
      go(); data = 24'h987654;
      go(); data = 24'h012345;
      go(); load = 1'b0;
      go();

      blink_en = 1'b1; n = ncyc;
      for (int k = 1; k <= 14; k++) begin
         on = (((k - 1) / 4) % 2) == 0;
         push(n + k, on ? V012345 : OFF6, 24'h012345, 20 + k);
      end
      repeat (14) go();
      blink_en = 1'b0;
      push(ncyc + 1, V012345, 24'h012345, 40);
      go(); go();

      blink_en = 1'b1; n = ncyc;
      for (int k = 1; k <= 14; k++) begin
         on = (((k - 1) / 4) % 2) == 0;
         push(n + k, on ? ((k <= 4) ? V012345 : V00ABCD) : OFF6,
              (k >= 4) ? 24'h00ABCD : 24'h012345, 40 + k);
      end
      repeat (3) go();
      load = 1'b1; data = 24'h00ABCD;
      go(); load = 1'b0;
      repeat (10) go();

      load = 1'b1; data = 24'h555555;
      #2 reset = 1'b1;
      #1 push_async(OFF6, 24'h0, 60);
      push(ncyc + 1, OFF6, 24'h0, 61);
      go(); go();
      reset = 1'b0; load = 1'b0; n = ncyc;
      for (int k = 1; k <= 6; k++) begin
         push(n + k, (k <= 4) ? {6{S0}} : OFF6, 24'h0, 70 + k);
      end

      repeat (8) go();
      if (q.size() != 0 || aq.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain pending=%0d expected 0", q.size() + aq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
